paralelo_serial_phy_tx: RTL and testbench
=========================================

Name: paralelo_serial_phy_tx

Overview:
- PHY transmit serializer: converts one 8-bit byte per 8 clk_32f cycles into a 1-bit MSB-first serial stream.
- Produces the comma-framed stream that the PHY receive deserializer aligns to and goes active on.
- After reset it emits INIT_COMMAS comma bytes (8'hBC) for alignment, then enters run mode.
- In run mode it sends the upstream byte when valid, otherwise the comma as the idle filler.

Parameters:
- INIT_COMMAS, 4, number of comma bytes sent after reset or resync before run mode; legal range 1..15.
- COMMA, 8'hBC, alignment/idle symbol.

Ports:
- clk_32f  in  1  bit clock; all state on rising edge.
- default_values  in  1  reset, asynchronous, active-low: 0 = reset.
- data_in  in  8  parallel byte; sampled only on an edge where ready_out=1.
- valid_in  in  1  data_in holds a real byte; sampled together with data_in.
- resync_in  in  1  level/pulse request to realign; sampled only at byte boundaries.
- data_out  out  1  registered serial bit, MSB of each byte first.
- ready_out  out  1  registered; high for exactly the cycle before a byte-load edge in which a user byte is accepted.
- active_out  out  1  registered; high while in RUN.

Behaviour:
- Reset (default_values=0, immediate):
  - data_out=0, ready_out=0, active_out=0.
  - bit_cnt=0, comma_cnt=0, frame=COMMA, state=SYNC.
- States: SYNC (send commas), RUN (send user bytes or commas).
- Bit datapath, every edge out of reset:
  - data_out <= frame[7-bit_cnt].
  - bit_cnt increments mod 8.
  - When bit_cnt==7 (byte-boundary edge), frame is reloaded.
- Reload rule:
  - SYNC: frame<=COMMA and comma_cnt++.
    - If comma_cnt==INIT_COMMAS-1: state<=RUN, active_out<=1, comma_cnt<=0.
    - On that same edge, frame is loaded by the RUN rule. This is the first user-byte sample.
  - RUN, resync_in=1: frame<=COMMA, state<=SYNC, active_out<=0, comma_cnt<=0. Any valid data_in is dropped; ready_out was high, so upstream must not treat that cycle as accepted when resync_in=1.
  - RUN, resync_in=0, valid_in=1: frame<=data_in.
  - RUN, resync_in=0, valid_in=0: frame<=COMMA.
  - resync_in is ignored in SYNC.
- ready_out:
  - ready_out <= (bit_cnt==6) && (state==RUN || comma_cnt==INIT_COMMAS-1).
  - So it is high exactly while bit_cnt==7 on a sampling boundary, and never high in any other cycle.
- Latency:
  - Byte accepted at edge E: its MSB appears on data_out after E+1, its LSB after E+8.
  - Back-to-back bytes give a gapless stream.
- Startup timing with INIT_COMMAS=4:
  - Edges 1..32 after reset release emit 4 commas: 10111100 repeated.
  - active_out rises at edge 32.
  - ready_out is high between edges 31 and 32.
  - The first user byte is output on edges 33..40.
- Data byte equal to COMMA is sent unmodified. Avoiding false alignment is upstream's responsibility.
- Reset asserted mid-byte: the partial byte is abandoned, outputs clear immediately, and the full comma preamble restarts on release.
- data_in and valid_in are don't-care when ready_out=0.

Decomposition:
- Shared phy package: COMMA constant (8'hBC), state encoding (SYNC, RUN), byte width 8.
- No sub-module. The 3-bit bit counter, comma counter, frame register and 2-state FSM fit in one module.
- The receive deserializer imports the same COMMA constant.

Test Plan:
- Reset release, valid_in=0: data_out over 32 edges = 0xBC x4 MSB-first; active_out=1 at edge 32; ready_out single pulse before edge 32.
- After sync, present 8'hA5 valid at the ready_out edge: data_out edges 33..40 = 1,0,1,0,0,1,0,1.
- Back-to-back 8'h01, 8'hFF, 8'h3C valid on three consecutive ready pulses: continuous 24-bit stream 00000001 11111111 00111100; ready_out period = 8 cycles.
- valid_in=0 in RUN: next byte is 0xBC; active_out stays 1.
- resync_in=1 at a RUN boundary with valid 8'h55: 0x55 not sent; 4 commas follow; active_out low for 32 cycles, then high.
- Loopback into the receive deserializer: it reaches active after the preamble and reproduces 8'hA5, 8'h5A in order; a mid-byte reset restarts the preamble from bit 7 of COMMA.

Source files
------------

// File: rtl/paralelo_serial_phy_tx_pkg.sv
// Shared PHY definitions: symbol width, comma symbol, link state encoding.
// The receive deserializer imports the same comma symbol so both ends agree.
package paralelo_serial_phy_tx_pkg;

  localparam int BYTE_W      = 8;
  localparam int BIT_CNT_W   = $clog2(BYTE_W);
  localparam int COMMA_CNT_W = 4;

  // Alignment / idle symbol (K28.5-style comma pattern 10111100).
  localparam logic [BYTE_W-1:0] COMMA_SYM = 8'hBC;

  // Link state: SYNC sends the comma preamble, RUN sends user bytes or idle commas.
  typedef enum logic {
    ST_SYNC = 1'b0,
    ST_RUN  = 1'b1
  } phy_state_t;

  // Byte loaded in run mode: the user byte when valid, otherwise the idle comma.
  function automatic logic [BYTE_W-1:0] run_byte(
    input logic              valid,
    input logic [BYTE_W-1:0] data,
    input logic [BYTE_W-1:0] comma
  );
    return valid ? data : comma;
  endfunction

endpackage

// File: rtl/paralelo_serial_phy_tx.sv
// PHY transmit serializer: one byte per 8 clk_32f cycles, MSB first.
// After reset or a resync request it sends INIT_COMMAS comma bytes so the
// receiver can align, then enters run mode where each byte boundary loads
// either the upstream byte (when valid) or the comma as idle filler.
module paralelo_serial_phy_tx
  import paralelo_serial_phy_tx_pkg::*;
#(
  parameter int                INIT_COMMAS = 4,          // 1..15
  parameter logic [BYTE_W-1:0] COMMA       = COMMA_SYM
) (
  input  logic              clk_32f,
  input  logic              default_values,   // async, active-low reset
  input  logic [BYTE_W-1:0] data_in,
  input  logic              valid_in,
  input  logic              resync_in,
  output logic              data_out,
  output logic              ready_out,
  output logic              active_out
);

  localparam logic [BIT_CNT_W-1:0]   LAST_BIT   = BIT_CNT_W'(BYTE_W - 1);
  localparam logic [BIT_CNT_W-1:0]   PREP_BIT   = BIT_CNT_W'(BYTE_W - 2);
  localparam logic [COMMA_CNT_W-1:0] LAST_COMMA = COMMA_CNT_W'(INIT_COMMAS - 1);

  logic [BIT_CNT_W-1:0]   bit_cnt_reg;
  logic [COMMA_CNT_W-1:0] comma_cnt_reg;
  logic [BYTE_W-1:0]      frame_reg;
  phy_state_t             state_reg;

  logic [BIT_CNT_W-1:0]   bit_idx;
  logic                   byte_end;
  logic                   preamble_done;
  logic [BYTE_W-1:0]      next_byte;

  // Bit position (MSB first), boundary and preamble-end decodes.
  always_comb begin
    bit_idx       = LAST_BIT - bit_cnt_reg;
    byte_end      = (bit_cnt_reg == LAST_BIT);
    preamble_done = (comma_cnt_reg == LAST_COMMA);
    next_byte     = run_byte(valid_in, data_in, COMMA);
  end

  // Serializer datapath, comma preamble counter and SYNC/RUN state machine.
  always_ff @(posedge clk_32f or negedge default_values) begin
    if (!default_values) begin
      data_out      <= 1'b0;
      ready_out     <= 1'b0;
      active_out    <= 1'b0;
      bit_cnt_reg   <= '0;
      comma_cnt_reg <= '0;
      frame_reg     <= COMMA;
      state_reg     <= ST_SYNC;
    end else begin
      data_out    <= frame_reg[bit_idx];
      bit_cnt_reg <= bit_cnt_reg + 1'b1;
      // Ready announces that the coming boundary edge samples a user byte:
      // every boundary in RUN, plus the boundary that ends the preamble.
      ready_out   <= (bit_cnt_reg == PREP_BIT) &&
                     ((state_reg == ST_RUN) || preamble_done);

      if (byte_end) begin
        if (state_reg == ST_SYNC) begin
          if (preamble_done) begin
            // Last preamble comma is out: go live and take the first user byte now.
            state_reg     <= ST_RUN;
            active_out    <= 1'b1;
            comma_cnt_reg <= '0;
            frame_reg     <= next_byte;
          end else begin
            frame_reg     <= COMMA;
            comma_cnt_reg <= comma_cnt_reg + 1'b1;
          end
        end else if (resync_in) begin
          // Realign: drop whatever was offered and restart the preamble.
          state_reg     <= ST_SYNC;
          active_out    <= 1'b0;
          comma_cnt_reg <= '0;
          frame_reg     <= COMMA;
        end else begin
          frame_reg <= next_byte;
        end
      end
    end
  end

endmodule

// File: tb/tb_paralelo_serial_phy_tx.sv
// Self-checking bench for paralelo_serial_phy_tx: a byte-level reference
// model predicts the serial stream, ready and active; directed phases pin the
// model with literal expectations, then a randomized phase stresses it.
module tb_paralelo_serial_phy_tx;

  localparam int          INIT_COMMAS = 4;
  localparam logic [7:0]  COMMA_TB    = 8'hBC;

  logic       clk_32f = 1'b0;
  logic       default_values = 1'b0;
  logic [7:0] data_in = 8'h00;
  logic       valid_in = 1'b0;
  logic       resync_in = 1'b0;
  logic       data_out;
  logic       ready_out;
  logic       active_out;

  paralelo_serial_phy_tx #(.INIT_COMMAS(INIT_COMMAS), .COMMA(COMMA_TB)) dut (
    .clk_32f        (clk_32f),
    .default_values (default_values),
    .data_in        (data_in),
    .valid_in       (valid_in),
    .resync_in      (resync_in),
    .data_out       (data_out),
    .ready_out      (ready_out),
    .active_out     (active_out)
  );

  always #5 clk_32f = ~clk_32f;

  int checks = 0;
  int errors = 0;

  // Reference model: stream of expected bits plus link timeline.
  logic      exp_q[$];
  int        n_edge;        // edges since reset release
  int        run_start;     // boundary edge at which the preamble ends
  logic      in_run;
  logic      exp_data, exp_ready, exp_active;
  logic [39:0] cap;         // last 40 serial bits seen from the DUT

  task automatic chk(input string name, input logic [39:0] act, input logic [39:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, req, $time);
    end
  endtask

  task automatic push_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) exp_q.push_back(b[i]);
  endtask

  task automatic model_reset();
    exp_q.delete();
    push_byte(COMMA_TB);
    n_edge     = 0;
    run_start  = 8 * INIT_COMMAS;
    in_run     = 1'b0;
    exp_data   = 1'b0;
    exp_ready  = 1'b0;
    exp_active = 1'b0;
  endtask

  // One rising edge of the link as seen byte-by-byte.
  task automatic model_edge(input logic v, input logic [7:0] d, input logic r);
    n_edge++;
    if (exp_q.size() == 0) exp_data = 1'bx;
    else exp_data = exp_q.pop_front();
    if (n_edge % 8 == 0) begin
      if (!in_run && n_edge == run_start) begin
        in_run = 1'b1;
        push_byte(v ? d : COMMA_TB);
      end else if (!in_run) begin
        push_byte(COMMA_TB);
      end else if (r) begin
        in_run    = 1'b0;
        run_start = n_edge + 8 * INIT_COMMAS;
        push_byte(COMMA_TB);
      end else begin
        push_byte(v ? d : COMMA_TB);
      end
    end
    exp_active = in_run;
    exp_ready  = ((n_edge + 1) % 8 == 0) && (in_run || (n_edge + 1 == run_start));
  endtask

  task automatic compare();
    chk("data_out",   {39'd0, data_out},   {39'd0, exp_data});
    chk("ready_out",  {39'd0, ready_out},  {39'd0, exp_ready});
    chk("active_out", {39'd0, active_out}, {39'd0, exp_active});
  endtask

  // Drive inputs at the falling edge, step the model on the rising edge,
  // compare on the next falling edge.
  task automatic cycle(input logic v, input logic [7:0] d, input logic r);
    valid_in  = v;
    data_in   = d;
    resync_in = r;
    @(posedge clk_32f);
    model_edge(v, d, r);
    @(negedge clk_32f);
    compare();
    cap = {cap[38:0], data_out};
  endtask

  // Seven cycles of don't-care inputs, then the boundary-edge inputs.
  task automatic send_byte(input logic v, input logic [7:0] d, input logic r);
    for (int i = 0; i < 7; i++)
      cycle(1'($urandom_range(1, 0)), 8'($urandom), 1'($urandom_range(1, 0)));
    cycle(v, d, r);
  endtask

  int lows;

  initial begin
    cap = '0;
    model_reset();
    repeat (3) @(negedge clk_32f);
    chk("reset_outputs", {37'd0, data_out, ready_out, active_out}, 40'd0);

    // Preamble with no user data, first user byte A5 at the ready edge.
    default_values = 1'b1;
    for (int i = 1; i <= 31; i++) cycle(1'b0, 8'h00, 1'b0);
    chk("ready_before_32",  {39'd0, ready_out},  40'd1);
    chk("active_before_32", {39'd0, active_out}, 40'd0);
    cycle(1'b1, 8'hA5, 1'b0);
    chk("active_at_32", {39'd0, active_out}, 40'd1);
    chk("ready_at_32",  {39'd0, ready_out},  40'd0);
    chk("preamble_bits", {8'd0, cap[31:0]}, {8'd0, 32'hBCBCBCBC});

    // Back-to-back bytes after A5.
    send_byte(1'b1, 8'h01, 1'b0);
    chk("first_40_bits", cap, {32'hBCBCBCBC, 8'hA5});
    send_byte(1'b1, 8'hFF, 1'b0);
    send_byte(1'b1, 8'h3C, 1'b0);
    send_byte(1'b0, 8'h77, 1'b0);
    chk("back_to_back", {16'd0, cap[23:0]}, {16'd0, 24'h01FF3C});
    send_byte(1'b0, 8'h00, 1'b0);
    chk("idle_comma", {32'd0, cap[7:0]}, {32'd0, 8'hBC});
    chk("idle_active", {39'd0, active_out}, 40'd1);

    // Resync with valid 55 at the boundary: 55 dropped, preamble repeats.
    send_byte(1'b1, 8'h55, 1'b1);
    lows = (active_out == 1'b0) ? 1 : 0;
    for (int i = 0; i < 31; i++) begin
      cycle(1'($urandom_range(1, 0)), 8'($urandom), 1'b0);
      if (active_out == 1'b0) lows++;
    end
    cycle(1'b1, 8'h5A, 1'b0);
    chk("resync_low_cycles", 40'(lows), 40'd32);
    chk("resync_active_back", {39'd0, active_out}, 40'd1);
    chk("resync_commas", {8'd0, cap[31:0]}, {8'd0, 32'hBCBCBCBC});
    send_byte(1'b0, 8'h00, 1'b0);
    chk("after_resync_byte", {32'd0, cap[7:0]}, {32'd0, 8'h5A});

    // Randomized traffic.
    for (int i = 0; i < 2000; i++)
      cycle($urandom_range(0, 9) < 7,
            ($urandom_range(0, 7) == 0) ? 8'hBC : 8'($urandom),
            $urandom_range(0, 99) < 4);

    // Mid-byte reset: outputs clear immediately, preamble restarts.
    for (int i = 0; i < 3 + int'($urandom_range(0, 6)); i++) cycle(1'b1, 8'h00, 1'b0);
    default_values = 1'b0;
    #1;
    chk("midbyte_reset_outputs", {37'd0, data_out, ready_out, active_out}, 40'd0);
    model_reset();
    repeat (2) @(negedge clk_32f);
    default_values = 1'b1;
    for (int i = 0; i < 32; i++) cycle(1'b1, 8'h00, 1'b0);
    chk("restart_preamble", {8'd0, cap[31:0]}, {8'd0, 32'hBCBCBCBC});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
